frame_fetch_engine: RTL

- Read-side counterpart to the line engine. It walks one frame buffer in raster order and issues DDR read commands through the shared address FIFO.
- It pops the returned 128-bit words from the read-data FIFO and forwards them, unchanged, to a downstream pixel FIFO that feeds the display path.
- It bounds the number of in-flight reads so read-data FIFO occupancy stays limited.

---
 rtl/frame_fetch_engine_pkg.sv | 38 +++
 rtl/frame_fetch_engine_if.sv | 40 ++++
 rtl/frame_fetch_engine_fetch_credit_counter.sv | 44 ++++
 rtl/frame_fetch_engine.sv | 139 +++++++++++++
 4 files changed

// File: rtl/frame_fetch_engine_pkg.sv
// Shared definitions for the frame fetch engine.
//   - DDR command encodings used on the address FIFO
//   - Frame-buffer address field widths and the frame_sel position in the base
//   - Burst length in 128-bit beats
//   - FSM state encoding
//   - fb_addr(): packs {pad, frame_sel, y, xb, pad} into a 31-bit DDR address
package frame_fetch_engine_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  localparam int ADDR_W        = 31;
  localparam int DATA_W        = 128;
  localparam int TOP_PAD_W     = 6;
  localparam int FRAME_SEL_W   = 6;
  localparam int Y_W           = 10;
  localparam int XB_W          = 7;
  localparam int LOW_PAD_W     = 2;
  // frame_sel is taken from FE_frame_base[27:22]
  localparam int FRAME_SEL_LSB = 22;

  localparam int BEATS_PER_BURST = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fe_state_t;

  function automatic logic [ADDR_W-1:0] fb_addr(
    input logic [FRAME_SEL_W-1:0] frame_sel,
    input logic [Y_W-1:0]         y,
    input logic [XB_W-1:0]        xb
  );
    return {{TOP_PAD_W{1'b0}}, frame_sel, y, xb, {LOW_PAD_W{1'b0}}};
  endfunction

endpackage

// File: rtl/frame_fetch_engine_if.sv
// Bus bundle for the frame fetch engine.
//   FE_*   : control (start pulse, frame base, ready, done pulse)
//   af_*   : DDR address/command FIFO write side
//   rdf_*  : DDR read-data FIFO read side (show-ahead head word)
//   pix_*  : downstream pixel FIFO write side
// master = the engine, slave = the surrounding system / memory controller.
interface frame_fetch_engine_if;
  import frame_fetch_engine_pkg::*;

  logic                FE_start;
  logic [31:0]         FE_frame_base;
  logic                FE_ready;
  logic                FE_done;

  logic                af_full;
  logic [ADDR_W-1:0]   af_addr_din;
  logic [2:0]          af_cmd_din;
  logic                af_wr_en;

  logic                rdf_valid;
  logic [DATA_W-1:0]   rdf_dout;
  logic                rdf_rd_en;

  logic                pix_full;
  logic [DATA_W-1:0]   pix_dout;
  logic                pix_wr_en;

  modport master (
    input  FE_start, FE_frame_base, af_full, rdf_valid, rdf_dout, pix_full,
    output FE_ready, FE_done, af_addr_din, af_cmd_din, af_wr_en,
           rdf_rd_en, pix_dout, pix_wr_en
  );

  modport slave (
    output FE_start, FE_frame_base, af_full, rdf_valid, rdf_dout, pix_full,
    input  FE_ready, FE_done, af_addr_din, af_cmd_din, af_wr_en,
           rdf_rd_en, pix_dout, pix_wr_en
  );

endinterface

// File: rtl/frame_fetch_engine_fetch_credit_counter.sv
// fetch_credit_counter: tracks read bursts issued but not fully returned.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : restart tracking at the start of a frame
//   issue     : a read command was accepted this cycle
//   pop       : a read-data beat was consumed this cycle
//   credit_ok : another command may be issued (outstanding < MAX_OUTSTANDING)
// Credit is purely registered: a burst that completes this cycle frees its
// slot only from the next cycle on.
module fetch_credit_counter
  import frame_fetch_engine_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic issue,
  input  logic pop,
  output logic credit_ok
);

  logic [3:0] outstanding_reg;
  logic       beat_reg;
  logic       burst_done;

  // The last beat of a burst retires one outstanding command
  assign burst_done = pop && (beat_reg == 1'(BEATS_PER_BURST - 1));
  assign credit_ok  = (outstanding_reg < 4'(MAX_OUTSTANDING));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      outstanding_reg <= '0;
      beat_reg        <= 1'b0;
    end else begin
      beat_reg <= beat_reg ^ pop;
      case ({issue, burst_done})
        2'b10:   outstanding_reg <= outstanding_reg + 4'd1;
        2'b01:   outstanding_reg <= outstanding_reg - 4'd1;
        default: outstanding_reg <= outstanding_reg;
      endcase
    end
  end

endmodule

// File: rtl/frame_fetch_engine.sv
// frame_fetch_engine: walks one frame buffer in raster order, issuing DDR
// read commands (one per 8 pixels, 2 beats each), and forwards the returned
// 128-bit words unchanged to the pixel FIFO.
//   clk, rst : clock, synchronous active-high reset
//   bus      : frame_fetch_engine_if.master (FE_*, af_*, rdf_*, pix_*)
// Parameters: H_PIXELS (multiple of 8), V_LINES (<= 1024),
//             MAX_OUTSTANDING (1..15) bursts in flight.
// Build option FE_CONTINUOUS_EN: after each frame the engine re-latches
// FE_frame_base and immediately fetches the next frame; only rst stops it.
module frame_fetch_engine
  import frame_fetch_engine_pkg::*;
#(
  parameter int H_PIXELS        = 800,
  parameter int V_LINES         = 600,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                  clk,
  input logic                  rst,
  frame_fetch_engine_if.master bus
);

  localparam int WORDS  = V_LINES * H_PIXELS / 4;
  localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [XB_W-1:0]   XB_LAST   = XB_W'(H_PIXELS / 8 - 1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(V_LINES - 1);
  localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(WORDS - 1);

  fe_state_t               state_reg;
  logic [FRAME_SEL_W-1:0]  frame_sel_reg;
  logic [Y_W-1:0]          y_reg;
  logic [XB_W-1:0]         xb_reg;
  logic [WCNT_W-1:0]       word_cnt_reg;
  logic                    ready_reg;

  logic start_acc;
  logic relaunch;
  logic credit_ok;
  logic issue;
  logic pop;
  logic last_pop;

  assign start_acc = (state_reg == ST_IDLE) && bus.FE_start;
  assign issue     = (state_reg == ST_FETCH) && !bus.af_full && credit_ok;
  assign pop       = bus.rdf_valid && !bus.pix_full && (state_reg != ST_IDLE);
  // Every command precedes its data, so the final word can only arrive in DRAIN
  assign last_pop  = pop && (state_reg == ST_DRAIN) && (word_cnt_reg == WORD_LAST);

`ifdef FE_CONTINUOUS_EN
  assign relaunch = last_pop;
`else
  assign relaunch = 1'b0;
`endif

  fetch_credit_counter #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_acc || relaunch),
    .issue    (issue),
    .pop      (pop),
    .credit_ok(credit_ok)
  );

  assign bus.af_addr_din = fb_addr(frame_sel_reg, y_reg, xb_reg);
  assign bus.af_cmd_din  = CMD_READ;
  assign bus.af_wr_en    = issue;
  assign bus.rdf_rd_en   = pop;
  assign bus.pix_wr_en   = pop;
  assign bus.pix_dout    = bus.rdf_dout;
  assign bus.FE_ready    = ready_reg;
  assign bus.FE_done     = last_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      frame_sel_reg <= '0;
      y_reg         <= '0;
      xb_reg        <= '0;
      word_cnt_reg  <= '0;
      ready_reg     <= 1'b1;
    end else begin
      // Returned words are counted in any active state
      if (pop) begin
        word_cnt_reg <= last_pop ? '0 : word_cnt_reg + 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (bus.FE_start) begin
            state_reg     <= ST_FETCH;
            frame_sel_reg <= bus.FE_frame_base[FRAME_SEL_LSB +: FRAME_SEL_W];
            y_reg         <= '0;
            xb_reg        <= '0;
            word_cnt_reg  <= '0;
            ready_reg     <= 1'b0;
          end
        end

        ST_FETCH: begin
          if (issue) begin
            if (xb_reg == XB_LAST) begin
              xb_reg <= '0;
              if (y_reg == Y_LAST) begin
                // Position wraps to the frame origin for any later restart
                y_reg     <= '0;
                state_reg <= ST_DRAIN;
              end else begin
                y_reg <= y_reg + 1'b1;
              end
            end else begin
              xb_reg <= xb_reg + 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          if (last_pop) begin
`ifdef FE_CONTINUOUS_EN
            // Next frame starts now; a new base takes effect at this boundary
            state_reg     <= ST_FETCH;
            frame_sel_reg <= bus.FE_frame_base[FRAME_SEL_LSB +: FRAME_SEL_W];
            ready_reg     <= 1'b0;
`else
            state_reg <= ST_IDLE;
            ready_reg <= 1'b1;
`endif
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule
